nibble_accum_alu: RTL and testbench
===================================

# nibble_accum_alu

Parametrised, pipelined successor to the single-cycle nibble adder in the Tiny Tapeout user area. It accepts two W-bit operands per valid cycle. It then either adds, subtracts, accumulates with wrap, or accumulates with saturation into an ACC_W-bit register. Results come out with a carry/borrow/overflow flag and a sample count. It sits between the `ui_in` operand nibbles and the `uo_out`/`uio_out` output pins of the top-level wrapper.

## Interface
Parameters:
- `W`, 4, operand width in bits (2..8).
- `ACC_W`, 8, result/accumulator width (≥ W+1).
- `CNT_W`, 4, sample-counter width.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `in_valid`  input  1  operands valid this cycle.
- `a`  input  W  operand A, unsigned.
- `b`  input  W  operand B, unsigned.
- `mode`  input  2  operation select, sampled with operands: 00 ADD, 01 SUB, 10 ACC, 11 ACC_SAT.
- `clr`  input  1  clear accumulator and count; acts in stage 2.
- `out_valid`  output  1  one-cycle pulse per completed operation.
- `result`  output  ACC_W  last result; holds between pulses.
- `flag`  output  1  carry (ADD/ACC), borrow (SUB) or saturation (ACC_SAT); holds with `result`.
- `count`  output  CNT_W  accumulated samples since last clear; saturates at 2^CNT_W−1.

## Operation
- Stage 1 register, loaded when `in_valid`=1:
  - `s1_sum` (W+1 bits) = a+b for modes 00/10/11, or a−b as W+1-bit two's complement for 01.
  - `s1_mode` = `mode`; `s1_valid` = `in_valid` (cleared when `in_valid`=0).
- Stage 2 executes when `s1_valid`=1:
  - ADD: `result` = zero-extended `s1_sum`; `flag` = `s1_sum[W]`. Accumulator and count untouched.
  - SUB: `result` = sign-extended `s1_sum`; `flag` = 1 if a<b. Accumulator and count untouched.
  - ACC: acc = (acc + `s1_sum`) mod 2^ACC_W; `flag` = carry out of bit ACC_W−1; `result` = new acc; count += 1 (saturating).
  - ACC_SAT: same as ACC, but on carry out acc = 2^ACC_W−1 and `flag`=1. Once saturated, acc stays at all-ones until `clr`.
- `clr` is sampled on the same edge that executes stage 2.
  - `clr`=1 without an ACC/ACC_SAT op in stage 2: acc=0, count=0. `result`, `flag` and `out_valid` unaffected.
  - `clr`=1 coincident with an ACC/ACC_SAT op: clear first, then accumulate. Gives acc = `s1_sum`, count = 1, `flag`=0.
- `out_valid` = registered `s1_valid`.
- Mixed modes may be issued back-to-back. The accumulator persists across ADD/SUB operations.

## Timing
- Latency: operands captured at edge k, `out_valid`=1 and `result` updated after edge k+1 (2 cycles).
- Throughput: one operation per cycle, no stalls, no backpressure.
- Accumulator feedback is single-cycle in stage 2. Back-to-back ACC ops must chain with no lost samples.
- Reset (`rst_n`=0 at an edge) forces the following to 0:
  - `s1_valid`, `s1_sum`, `s1_mode`
  - acc, `count`, `result`, `flag`, `out_valid`
- Reset mid-operation drops in-flight stage-1 data. No `out_valid` pulse follows for operands captured before reset.
- Count saturation: at 2^CNT_W−1, further accumulates leave `count` unchanged.

## Configuration
- `NIBBLE_ACCUM_SAT_EN` defined: ACC_SAT mode behaves as specified above.
- Undefined: saturation logic is compiled out. Mode 11 behaves exactly as mode 10 (wrap, `flag` = carry).

## Test plan
Defaults W=4, ACC_W=8, CNT_W=4.
- ADD a=15, b=15, single `in_valid` pulse → two cycles later `out_valid`=1 for one cycle, `result`=0x1E, `flag`=1, `count`=0.
- SUB a=3, b=5 → `result`=0xFE, `flag`=1. SUB a=9, b=4 → `result`=0x05, `flag`=0.
- `clr`, then 9 back-to-back ACC ops with a=15, b=15:
  - After the 8th: `result`=240, `flag`=0, `count`=8.
  - After the 9th: `result`=14, `flag`=1, `count`=9.
  - Continue to 20 samples: `count` holds at 15.
- With `NIBBLE_ACCUM_SAT_EN`, same 9-sample sequence in ACC_SAT → 9th gives `result`=255, `flag`=1. A 10th sample keeps 255. Without the macro it matches the wrap case.
- Accumulator at 240, then `clr` asserted on the edge where an ACC op of 30 executes → `result`=30, `count`=1, `flag`=0.
- ACC op with `in_valid`=1, then `rst_n`=0 on the next edge → `out_valid` never pulses. All outputs read 0 after reset.

Source files
------------

// File: rtl/nibble_accum_alu.sv
// nibble_accum_alu: two-stage pipelined add / subtract / accumulate unit.
// Stage 1 registers the W+1-bit operand sum or difference. Stage 2 either
// produces an ADD/SUB result or folds the sum into the accumulator.
// Optional feature macro: NIBBLE_ACCUM_SAT_EN enables saturating accumulate
// (mode 11). When the macro is undefined, mode 11 wraps exactly like mode 10.
module nibble_accum_alu #(
  parameter int unsigned W     = 4,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             out_valid,
  output logic [ACC_W-1:0] result,
  output logic             flag,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ACC     = 2'b10,
    OP_ACC_SAT = 2'b11
  } op_e;

  logic [W:0]       s1_sum_d, s1_sum_q;
  op_e              s1_mode_q;
  logic             s1_valid_q;

  logic [ACC_W-1:0] acc_d, acc_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [ACC_W-1:0] result_d, result_q;
  logic             flag_d, flag_q;
  logic             out_valid_q;

  logic [ACC_W-1:0] acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic [ACC_W:0]   acc_sum;

  // Stage 1 arithmetic: W+1-bit sum, or two's-complement difference for SUB
  always_comb begin
    if (mode == OP_SUB) s1_sum_d = {1'b0, a} - {1'b0, b};
    else                s1_sum_d = {1'b0, a} + {1'b0, b};
  end

  // Stage 1 register: operands are captured only on valid cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_mode_q  <= OP_ADD;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sum_q  <= s1_sum_d;
        s1_mode_q <= op_e'(mode);
      end
    end
  end

  // Stage 2 execute. clr zeroes the accumulator base first, so a coincident
  // accumulate starts from zero.
  always_comb begin
    acc_base = clr ? '0 : acc_q;
    cnt_base = clr ? '0 : cnt_q;
    acc_sum  = {1'b0, acc_base} + (ACC_W+1)'(s1_sum_q);

    acc_d    = acc_base;
    cnt_d    = cnt_base;
    result_d = result_q;
    flag_d   = flag_q;

    if (s1_valid_q) begin
      unique case (s1_mode_q)
        OP_ADD: begin
          result_d = ACC_W'(s1_sum_q);
          flag_d   = s1_sum_q[W];
        end
        OP_SUB: begin
          // The sign bit of the W+1-bit difference is set exactly when a < b
          result_d = ACC_W'($signed(s1_sum_q));
          flag_d   = s1_sum_q[W];
        end
        OP_ACC, OP_ACC_SAT: begin
          acc_d  = acc_sum[ACC_W-1:0];
          flag_d = acc_sum[ACC_W];
`ifdef NIBBLE_ACCUM_SAT_EN
          if ((s1_mode_q == OP_ACC_SAT) && acc_sum[ACC_W]) acc_d = '1;
`endif
          result_d = acc_d;
          cnt_d    = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
        end
      endcase
    end
  end

  // Stage 2 registers: accumulator, count, held result/flag and valid pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      flag_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      flag_q      <= flag_d;
      out_valid_q <= s1_valid_q;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag      = flag_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_nibble_accum_alu.sv
// Testbench for nibble_accum_alu: directed checks plus randomized traffic
// compared against an integer reference model of the operation rules.
module tb_nibble_accum_alu;

  localparam int unsigned W     = 4;
  localparam int unsigned ACC_W = 8;
  localparam int unsigned CNT_W = 4;
`ifdef NIBBLE_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [W-1:0]     a, b;
  logic [1:0]       mode;
  logic             clr;
  logic             out_valid;
  logic [ACC_W-1:0] result;
  logic             flag;
  logic [CNT_W-1:0] count;

  nibble_accum_alu #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .mode     (mode),
    .clr      (clr),
    .out_valid(out_valid),
    .result   (result),
    .flag     (flag),
    .count    (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int unsigned m_acc, m_cnt, m_res;
  bit          m_flag, m_ov;
  bit          p_v;
  int unsigned p_a, p_b, p_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge(input bit v, input int unsigned aa, input int unsigned bb,
                            input int unsigned m, input bit c, input bit r);
    int unsigned s;
    if (!r) begin
      m_acc = 0; m_cnt = 0; m_res = 0; m_flag = 0; m_ov = 0; p_v = 0;
      p_a = 0; p_b = 0; p_m = 0;
      return;
    end
    m_ov = p_v;
    if (c) begin
      m_acc = 0;
      m_cnt = 0;
    end
    if (p_v) begin
      if (p_m == 0) begin
        m_res  = p_a + p_b;
        m_flag = (m_res >= (1 << W));
      end else if (p_m == 1) begin
        m_res  = (p_a + (1 << ACC_W) - p_b) % (1 << ACC_W);
        m_flag = (p_a < p_b);
      end else begin
        s      = m_acc + p_a + p_b;
        m_flag = (s >= (1 << ACC_W));
        m_acc  = s % (1 << ACC_W);
        if (SAT && p_m == 3 && m_flag) m_acc = (1 << ACC_W) - 1;
        m_res  = m_acc;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      end
    end
    p_v = v;
    if (v) begin
      p_a = aa; p_b = bb; p_m = m;
    end
  endtask

  // Drive one cycle of inputs, step model and DUT, then compare all outputs
  task automatic step(input bit v, input int unsigned aa, input int unsigned bb,
                      input int unsigned m, input bit c, input bit r);
    in_valid = v;
    a        = W'(aa);
    b        = W'(bb);
    mode     = 2'(m);
    clr      = c;
    rst_n    = r;
    @(posedge clk);
    model_edge(v, aa, bb, m, c, r);
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(m_ov));
    check_eq("result",    32'(result),    m_res);
    check_eq("flag",      32'(flag),      32'(m_flag));
    check_eq("count",     32'(count),     m_cnt);
  endtask

  initial begin
    in_valid = 0; a = '0; b = '0; mode = '0; clr = 0; rst_n = 0;
    m_acc = 0; m_cnt = 0; m_res = 0; m_flag = 0; m_ov = 0; p_v = 0;
    p_a = 0; p_b = 0; p_m = 0;

    // Reset state
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("rst_result", 32'(result), 0);
    check_eq("rst_valid",  32'(out_valid), 0);
    check_eq("rst_count",  32'(count), 0);

    // ADD 15+15
    step(1, 15, 15, 0, 0, 1);
    check_eq("add_lat_valid", 32'(out_valid), 0);
    step(0, 0, 0, 0, 0, 1);
    check_eq("add_valid", 32'(out_valid), 1);
    check_eq("add_result", 32'(result), 32'h1E);
    check_eq("add_flag", 32'(flag), 1);
    check_eq("add_count", 32'(count), 0);
    step(0, 0, 0, 0, 0, 1);
    check_eq("add_pulse_end", 32'(out_valid), 0);
    check_eq("add_hold", 32'(result), 32'h1E);

    // SUB cases, back-to-back
    step(1, 3, 5, 1, 0, 1);
    step(1, 9, 4, 1, 0, 1);
    check_eq("sub1_result", 32'(result), 32'hFE);
    check_eq("sub1_flag", 32'(flag), 1);
    step(0, 0, 0, 0, 0, 1);
    check_eq("sub2_result", 32'(result), 32'h05);
    check_eq("sub2_flag", 32'(flag), 0);

    // Wrapping accumulate, 20 samples of 30
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 15, 15, 2, 0, 1);
      if (i == 8) begin
        check_eq("acc8_result", 32'(result), 240);
        check_eq("acc8_flag", 32'(flag), 0);
        check_eq("acc8_count", 32'(count), 8);
      end
      if (i == 9) begin
        check_eq("acc9_result", 32'(result), 14);
        check_eq("acc9_flag", 32'(flag), 1);
        check_eq("acc9_count", 32'(count), 9);
      end
    end
    step(0, 0, 0, 0, 0, 1);
    check_eq("acc_count_sat", 32'(count), 15);

    // Saturating accumulate, 10 samples of 30
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 15, 15, 3, 0, 1);
      if (i == 9) begin
        check_eq("sat9_result", 32'(result), SAT ? 255 : 14);
        check_eq("sat9_flag", 32'(flag), 1);
      end
    end
    step(0, 0, 0, 0, 0, 1);
    check_eq("sat10_result", 32'(result), SAT ? 255 : 44);

    // clr coincident with an executing accumulate
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 15, 15, 2, 0, 1);
    step(1, 15, 15, 2, 0, 1);
    check_eq("pre_clr_result", 32'(result), 240);
    step(0, 0, 0, 0, 1, 1);
    check_eq("clracc_result", 32'(result), 30);
    check_eq("clracc_count", 32'(count), 1);
    check_eq("clracc_flag", 32'(flag), 0);

    // Reset drops an in-flight operation
    step(1, 15, 15, 2, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check_eq("midrst_result", 32'(result), 0);
    check_eq("midrst_count", 32'(count), 0);
    check_eq("midrst_flag", 32'(flag), 0);
    check_eq("midrst_valid", 32'(out_valid), 0);
    step(0, 0, 0, 0, 0, 1);
    check_eq("midrst_nopulse1", 32'(out_valid), 0);
    step(0, 0, 0, 0, 0, 1);
    check_eq("midrst_nopulse2", 32'(out_valid), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0),
           $urandom_range(0, (1 << W) - 1),
           $urandom_range(0, (1 << W) - 1),
           $urandom_range(0, 3),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 63) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
